// File: rtl/seg7_capture_decoder_if.sv
// Segment bus into the capture decoder plus its registered decode/status outputs.
interface seg7_capture_decoder_if;
    logic [6:0] seg;
    logic [3:0] value;
    logic       value_valid;
    logic       blank;
    logic       invalid;
    logic       change_pulse;
    logic [7:0] err_count;
    logic       locked;

    // No handshake: seg is free-running, and change_pulse is a one-cycle strobe.
    // value/value_valid/blank/invalid/err_count are already updated in the strobe cycle
    // and hold until the next accepted change. locked mirrors the filter FSM state.
    modport master (
        output seg,
        input  value, value_valid, blank, invalid, change_pulse, err_count, locked
    );
    modport slave (
        input  seg,
        output value, value_valid, blank, invalid, change_pulse, err_count, locked
    );
endinterface

// File: rtl/seg7_capture_decoder.sv
// Synchronizes an active-low 7-segment bus, filters glitches with a stability count,
// and decodes each newly accepted pattern to a hex digit with blank/invalid status.
module seg7_capture_decoder #(
    parameter int STABLE_CYCLES = 4
) (
    input  logic                    clock,
    input  logic                    reset_n,
    seg7_capture_decoder_if.slave   bus
);
    typedef enum logic {TRACK = 1'b0, LOCKED = 1'b1} state_t;

    localparam logic [7:0] STABLE = 8'(STABLE_CYCLES);
    localparam logic [6:0] BLANK_PAT = 7'h7F;

    state_t     state, state_next;
    logic [6:0] s1, s2, prev, accepted;
    logic [7:0] cnt;
    logic       differ, accept_edge, new_pattern;
    logic       dec_legal;
    logic [3:0] dec_digit;

    assign differ      = (s2 != prev);
    assign new_pattern = accept_edge && (s2 != accepted);
    assign bus.locked  = (state == LOCKED);

    always_comb begin
        state_next  = state;
        accept_edge = 1'b0;
        case (state)
            TRACK: begin
                if (!differ && cnt == STABLE - 8'd1) begin
                    accept_edge = 1'b1;
                    state_next  = LOCKED;
                end
            end
            LOCKED: begin
                if (differ) state_next = TRACK;
            end
            default: state_next = TRACK;
        endcase
    end

    // Active-low patterns, bit order g..a.
    always_comb begin
        dec_legal = 1'b1;
        dec_digit = 4'h0;
        case (s2)
            7'h40: dec_digit = 4'h0;
            7'h79: dec_digit = 4'h1;
            7'h24: dec_digit = 4'h2;
            7'h30: dec_digit = 4'h3;
            7'h19: dec_digit = 4'h4;
            7'h12: dec_digit = 4'h5;
            7'h02: dec_digit = 4'h6;
            7'h78: dec_digit = 4'h7;
            7'h00: dec_digit = 4'h8;
            7'h10: dec_digit = 4'h9;
            7'h08: dec_digit = 4'hA;
            7'h03: dec_digit = 4'hB;
            7'h46: dec_digit = 4'hC;
            7'h21: dec_digit = 4'hD;
            7'h06: dec_digit = 4'hE;
            7'h0E: dec_digit = 4'hF;
            default: dec_legal = 1'b0;
        endcase
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            s1               <= BLANK_PAT;
            s2               <= BLANK_PAT;
            prev             <= BLANK_PAT;
            accepted         <= BLANK_PAT;
            cnt              <= STABLE;
            state            <= LOCKED;
            bus.value        <= 4'h0;
            bus.value_valid  <= 1'b0;
            bus.blank        <= 1'b1;
            bus.invalid      <= 1'b0;
            bus.change_pulse <= 1'b0;
            bus.err_count    <= 8'h00;
        end else begin
            s1               <= bus.seg;
            s2               <= s1;
            prev             <= s2;
            state            <= state_next;
            bus.change_pulse <= new_pattern;
            if (differ)
                cnt <= 8'd1;
            else if (cnt != STABLE)
                cnt <= cnt + 8'd1;
            // A re-stable onto the already accepted pattern leaves every output alone.
            if (new_pattern) begin
                accepted <= s2;
                if (dec_legal) begin
                    bus.value       <= dec_digit;
                    bus.value_valid <= 1'b1;
                    bus.blank       <= 1'b0;
                    bus.invalid     <= 1'b0;
                end else if (s2 == BLANK_PAT) begin
                    bus.value_valid <= 1'b0;
                    bus.blank       <= 1'b1;
                    bus.invalid     <= 1'b0;
                end else begin
                    bus.value_valid <= 1'b0;
                    bus.blank       <= 1'b0;
                    bus.invalid     <= 1'b1;
                    if (bus.err_count != 8'hFF)
                        bus.err_count <= bus.err_count + 8'd1;
                end
            end
        end
    end
endmodule

// File: tb/tb_seg7_capture_decoder.sv
// Directed-vector bench for seg7_capture_decoder: the driver pushes the expected status and
// acceptance edge per pattern, and a monitor pops and compares on every change_pulse.
module tb_seg7_capture_decoder;
    localparam int S = 4;

    logic clock = 1'b0;
    logic reset_n = 1'b0;
    seg7_capture_decoder_if bus ();

    seg7_capture_decoder #(.STABLE_CYCLES(S)) dut (
        .clock   (clock),
        .reset_n (reset_n),
        .bus     (bus)
    );

    always #5 clock = ~clock;

    int edge_cnt = 0;
    always @(posedge clock) edge_cnt <= edge_cnt + 1;

    int tests = 0;
    int fails = 0;

    logic [14:0] exp_q[$];
    int          exp_edge_q[$];

    logic [6:0] seg_tab [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                 7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

    logic [6:0] m_acc;
    logic [3:0] m_val;
    logic       m_vv, m_bl, m_inv;
    logic [7:0] m_err;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at edge %0d", name, act, exp, edge_cnt);
        end
    endtask

    task automatic model_reset();
        m_acc = 7'h7F; m_val = 4'h0; m_vv = 1'b0; m_bl = 1'b1; m_inv = 1'b0; m_err = 8'h00;
    endtask

    task automatic model_accept(input logic [6:0] p);
        logic legal;
        legal = 1'b0;
        for (int d = 0; d < 16; d++) begin
            if (seg_tab[d] == p) begin
                legal = 1'b1;
                m_val = 4'(d);
            end
        end
        m_acc = p;
        if (legal) begin
            m_vv = 1'b1; m_bl = 1'b0; m_inv = 1'b0;
        end else if (p == 7'h7F) begin
            m_vv = 1'b0; m_bl = 1'b1; m_inv = 1'b0;
        end else begin
            m_vv = 1'b0; m_bl = 1'b0; m_inv = 1'b1;
            if (m_err != 8'hFF) m_err = m_err + 8'd1;
        end
    endtask

    // Called #1 after a rising edge; seg is first sampled on the next edge (k),
    // so acceptance lands on edge k+1+S = edge_cnt+S+2.
    task automatic drive(input logic [6:0] p, input int hold);
        bus.seg = p;
        if (hold >= S && p != m_acc) begin
            model_accept(p);
            exp_q.push_back({m_val, m_vv, m_bl, m_inv, m_err});
            exp_edge_q.push_back(edge_cnt + S + 2);
        end
        repeat (hold) @(posedge clock);
        #1;
    endtask

    task automatic wait_drain(input string name);
        for (int i = 0; i < 200 && exp_q.size() > 0; i++) @(posedge clock);
        #1;
        check(name, exp_q.size(), 0);
        exp_q.delete();
        exp_edge_q.delete();
    endtask

    task automatic check_status(input string name);
        check(name, {bus.value, bus.value_valid, bus.blank, bus.invalid, bus.err_count},
              {m_val, m_vv, m_bl, m_inv, m_err});
    endtask

    always @(negedge clock) begin
        if (reset_n && bus.change_pulse === 1'b1) begin
            if (exp_q.size() == 0) begin
                check("unexpected_pulse", 1, 0);
            end else begin
                check("pulse_status",
                      {bus.value, bus.value_valid, bus.blank, bus.invalid, bus.err_count},
                      exp_q.pop_front());
                check("pulse_edge", edge_cnt, exp_edge_q.pop_front());
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("[TB] %0d tests run, %0d failed", tests, fails + 1);
        $fatal(1, "watchdog");
    end

    initial begin
        model_reset();
        bus.seg = 7'h40;
        reset_n = 1'b0;
        repeat (3) @(posedge clock);
        #1;
        check("reset_outputs",
              {bus.value, bus.value_valid, bus.blank, bus.invalid, bus.change_pulse, bus.err_count},
              {4'h0, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00});
        check("reset_locked", bus.locked, 1);
        reset_n = 1'b1;
        drive(7'h40, 10);
        wait_drain("drain_reset");
        check_status("after_reset_digit0");

        drive(7'h7F, 10);
        for (int d = 0; d < 16; d++) drive(seg_tab[d], 10);
        wait_drain("drain_digits");
        check("digits_last_value", bus.value, 4'hF);

        drive(seg_tab[3], 10);
        wait_drain("drain_digit3");
        drive(7'h00, S - 1);
        drive(seg_tab[3], 10);
        wait_drain("drain_short_glitch");
        check("glitch_value_held", bus.value, 4'h3);
        drive(7'h00, S);
        wait_drain("drain_long_glitch");
        check("glitch_accepted_8", bus.value, 4'h8);

        for (int i = 0; i < 20; i++) begin
            drive(7'h55, 1);
            drive(7'h2A, 1);
        end
        check("toggle_unlocked", bus.locked, 0);
        drive(seg_tab[8], 10);
        wait_drain("drain_toggle");
        check_status("toggle_outputs_held");

        drive(7'h55, 10);
        wait_drain("drain_invalid");
        check("invalid_flag", {bus.invalid, bus.err_count, bus.value}, {1'b1, 8'd1, 4'h8});
        drive(7'h7F, 10);
        wait_drain("drain_blank");
        check("blank_flag", {bus.blank, bus.invalid, bus.err_count}, {1'b1, 1'b0, 8'd1});

        for (int i = 0; i < 300; i++) drive((i % 2 == 0) ? 7'h55 : 7'h2A, 10);
        wait_drain("drain_saturate");
        check("err_saturated", bus.err_count, 8'hFF);
        drive(7'h55, 10);
        wait_drain("drain_saturate_hold");
        check("err_stays_saturated", bus.err_count, 8'hFF);

        drive(seg_tab[5], 10);
        wait_drain("drain_digit5");
        bus.seg = seg_tab[9];
        repeat (4) @(posedge clock);
        #1;
        reset_n = 1'b0;
        @(posedge clock);
        #1;
        model_reset();
        check("midreset_outputs",
              {bus.value, bus.value_valid, bus.blank, bus.invalid, bus.change_pulse, bus.err_count},
              {4'h0, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00});
        repeat (2) @(posedge clock);
        #1;
        reset_n = 1'b1;
        drive(seg_tab[9], 10);
        wait_drain("drain_midreset");
        check_status("midreset_reaccept_9");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
